adc_controller: RTL and testbench

ADC_CONTROLLER -- requirements
Module: adc_controller

---
 rtl/adc_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_adc_controller.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : adc_controller
// Description : Conversion sequencer for a serial-output SAR ADC. A start
//               request pulses CNVST low, waits for BUSY to drop, then clocks
//               16 bits out of SDOUT (MSB first) and presents them on data
//               with a one-cycle data_enable strobe. A sticky error flag
//               records protocol misuse and ADC read errors.
//
// Parameters  : SCLK_HALF     clk_in cycles per SCLK high / low phase (>= 1)
//               CNV_CYCLES    clk_in cycles CNVST is held low (>= 1)
//               BUSY_TIMEOUT  maximum clk_in cycles spent waiting for BUSY low
//
// Ports       : clk_in       system clock, rising edge
//               reset        asynchronous active-high reset
//               start        one-cycle conversion request
//               data_enable  one-cycle strobe, data valid
//               error        sticky error flag (cleared only by reset)
//               data[15:0]   last converted sample
//               SCLK, CNVST, RD, CS, RESET, OB2C, PD   ADC control pins
//               SDOUT, RDERROR, BUSY                   ADC status / data pins
//
// Options     : ADC_BUSY_TIMEOUT_EN  when defined, a BUSY wait lasting
//               BUSY_TIMEOUT cycles aborts to IDLE and sets error. When
//               undefined the controller waits for BUSY indefinitely.
//
// Revision    : 1.0  initial release
// ============================================================================
module adc_controller #(
    parameter int SCLK_HALF    = 2,
    parameter int CNV_CYCLES   = 4,
    parameter int BUSY_TIMEOUT = 1023
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        start,
    output logic        data_enable,
    output logic        error,
    output logic [15:0] data,
    output logic        SCLK,
    output logic        CNVST,
    output logic        RD,
    output logic        CS,
    output logic        RESET,
    output logic        OB2C,
    output logic        PD,
    input  logic        SDOUT,
    input  logic        RDERROR,
    input  logic        BUSY
);

    // Shared down-counter covers both the CNVST low time and SCLK phases.
    localparam int c_CNT_MAX = (CNV_CYCLES > SCLK_HALF) ? CNV_CYCLES : SCLK_HALF;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    // Elapsed-cycle counter for WAIT_BUSY; wide enough to reach the timeout
    // value and the blanking threshold. Saturates so it never wraps.
    localparam int                c_WAIT_W   = $clog2(BUSY_TIMEOUT + 3);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = '1;
    localparam logic [c_WAIT_W-1:0] c_BLANK    = c_WAIT_W'(2);

    localparam logic [2:0] c_RST_HOLD = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CONV      = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_READ      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t                r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_WAIT_W-1:0]   r_wait_cnt;
    logic [4:0]            r_bit_cnt;
    logic [15:0]           r_shift;
    logic [2:0]            r_rst_cnt;
    logic [15:0]           r_data;
    logic                  r_data_en;
    logic                  r_error;
    logic                  r_sclk;
    logic                  r_cnvst;
    logic                  r_cs;
    logic                  r_reset_out;

    logic                  w_busy_ready;

    // BUSY is ignored for the first two WAIT_BUSY cycles; it may not have
    // risen yet right after CNVST returns high.
    assign w_busy_ready = (r_wait_cnt >= c_BLANK) && !BUSY;

`ifdef ADC_BUSY_TIMEOUT_EN
    logic                  w_timeout;
    assign w_timeout = (r_wait_cnt == c_WAIT_W'(BUSY_TIMEOUT - 1));
`endif

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_wait_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rst_cnt   <= c_RST_HOLD;
            r_data      <= '0;
            r_data_en   <= 1'b0;
            r_error     <= 1'b0;
            r_sclk      <= 1'b0;
            r_cnvst     <= 1'b1;
            r_cs        <= 1'b1;
            r_reset_out <= 1'b1;
        end else begin
            r_data_en <= 1'b0;

            // Hold the ADC RESET pin for a fixed number of cycles after release.
            if (r_rst_cnt != 3'd0) begin
                r_rst_cnt <= r_rst_cnt - 3'd1;
                if (r_rst_cnt == 3'd1) begin
                    r_reset_out <= 1'b0;
                end
            end

            // A request arriving outside IDLE (including the edge that enters
            // DONE) is dropped and flagged.
            if (start && (r_state != S_IDLE)) begin
                r_error <= 1'b1;
            end

            if ((r_state == S_READ) && RDERROR) begin
                r_error <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnvst <= 1'b1;
                    r_cs    <= 1'b1;
                    r_sclk  <= 1'b0;
                    // Requests during the ADC reset hold are silently ignored.
                    if (start && !r_reset_out) begin
                        r_state <= S_CONV;
                        r_cnvst <= 1'b0;
                        r_cnt   <= c_CNT_W'(CNV_CYCLES - 1);
                    end
                end

                S_CONV: begin
                    if (r_cnt == '0) begin
                        r_cnvst    <= 1'b1;
                        r_wait_cnt <= '0;
                        r_state    <= S_WAIT_BUSY;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end

                S_WAIT_BUSY: begin
                    if (w_busy_ready) begin
                        r_state   <= S_READ;
                        r_cs      <= 1'b0;
                        r_sclk    <= 1'b1;
                        r_cnt     <= c_CNT_W'(SCLK_HALF - 1);
                        r_bit_cnt <= '0;
                    end
`ifdef ADC_BUSY_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_error <= 1'b1;
                        r_state <= S_IDLE;
                    end
`endif
                    else if (r_wait_cnt != c_WAIT_MAX) begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                    end
                end

                S_READ: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end else if (r_sclk) begin
                        // High-to-low SCLK edge: capture the bit the ADC
                        // has been presenting during the high phase.
                        r_sclk    <= 1'b0;
                        r_shift   <= {r_shift[14:0], SDOUT};
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        r_cnt     <= c_CNT_W'(SCLK_HALF - 1);
                    end else if (r_bit_cnt == 5'd16) begin
                        // Low phase of the 16th period finished.
                        r_state   <= S_DONE;
                        r_cs      <= 1'b1;
                        r_data    <= r_shift;
                        r_data_en <= 1'b1;
                    end else begin
                        r_sclk <= 1'b1;
                        r_cnt  <= c_CNT_W'(SCLK_HALF - 1);
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_enable = r_data_en;
    assign error       = r_error;
    assign data        = r_data;
    assign SCLK        = r_sclk;
    assign CNVST       = r_cnvst;
    assign CS          = r_cs;
    assign RESET       = r_reset_out;

    // Fixed strap pins: straight-binary output, powered up, serial read mode.
    assign OB2C        = 1'b1;
    assign PD          = 1'b0;
    assign RD          = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_adc_controller.sv
`default_nettype none
`timescale 1ns/1ps
module tb_adc_controller;

    localparam int T_CNV     = 4;
    localparam int T_SH      = 2;
    localparam int T_TO      = 1023;
    localparam int BUSY_LEN  = 3;
    // start cycle + CNVST low + WAIT_BUSY (BUSY_LEN high samples + 1) + read + DONE
    localparam int EXP_LAT   = 1 + T_CNV + (1 + BUSY_LEN) + 32 * T_SH + 1;   // 74

    logic        clk_in = 1'b0;
    logic        reset;
    logic        start;
    logic        data_enable;
    logic        error;
    logic [15:0] data;
    logic        SCLK, CNVST, RD, CS, RESET, OB2C, PD;
    logic        SDOUT, RDERROR, BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    // ADC model configuration (written only by the test sequence)
    logic [15:0] sdo_word   = 16'h0000;
    int          busy_len   = BUSY_LEN;
    int          rderr_bit  = -1;
    bit          busy_stuck = 1'b0;

    // Model / monitor state (written only by the monitor)
    int m_busy_cnt = 0;
    bit m_prev_cnvst = 1'b1;
    bit m_prev_sclk  = 1'b0;
    int m_bit = 0;
    int m_cnv_run = 0, m_cs_run = 0, m_sclk_run = 0, m_de_run = 0;
    int last_cnv_low = 0, last_cs_low = 0, last_sclk = 0, last_de_w = 0;
    int de_total = 0;

    adc_controller dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .start       (start),
        .data_enable (data_enable),
        .error       (error),
        .data        (data),
        .SCLK        (SCLK),
        .CNVST       (CNVST),
        .RD          (RD),
        .CS          (CS),
        .RESET       (RESET),
        .OB2C        (OB2C),
        .PD          (PD),
        .SDOUT       (SDOUT),
        .RDERROR     (RDERROR),
        .BUSY        (BUSY)
    );

    always #5 clk_in = ~clk_in;

    // ADC behavioural model and pin statistics, updated on the falling edge.
    always @(negedge clk_in) begin
        if (!CNVST) m_cnv_run++;
        else if (m_cnv_run != 0) begin last_cnv_low = m_cnv_run; m_cnv_run = 0; end
        if (!CS) begin
            m_cs_run++;
            if (SCLK && !m_prev_sclk) m_sclk_run++;
        end else if (m_cs_run != 0) begin
            last_cs_low = m_cs_run; last_sclk = m_sclk_run; m_cs_run = 0; m_sclk_run = 0;
        end
        if (data_enable === 1'b1) begin de_total++; m_de_run++; end
        else if (m_de_run != 0) begin last_de_w = m_de_run; m_de_run = 0; end

        if (CNVST && !m_prev_cnvst) m_busy_cnt = busy_len;
        else if (m_busy_cnt > 0) m_busy_cnt--;
        BUSY = busy_stuck || (m_busy_cnt != 0);
        m_prev_cnvst = CNVST;

        if (CS) m_bit = 0;
        else if (m_prev_sclk && !SCLK) m_bit++;
        m_prev_sclk = SCLK;
        SDOUT   = (m_bit < 16) ? sdo_word[15 - m_bit] : 1'b0;
        RDERROR = !CS && (m_bit == rderr_bit);
    end

    task automatic launch();
        @(negedge clk_in); start = 1'b1;
        @(negedge clk_in); start = 1'b0;
    endtask

    task automatic wait_de(input int bound, output bit seen, output int n);
        seen = 1'b0; n = 0;
        while (!seen && n < bound) begin
            @(negedge clk_in); n++;
            if (data_enable === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic settle();
        repeat (2) @(negedge clk_in);
        @(posedge clk_in); #1;
    endtask

    task automatic do_reset();
        @(posedge clk_in); #1 reset = 1'b1;
        repeat (2) @(posedge clk_in);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        int hi;
        repeat (3) @(posedge clk_in); #1;
        n_checks++; if (data !== 16'h0000) begin n_fail++; $display("FAIL rst_data got=%h exp=0000", data); end
        n_checks++; if (data_enable !== 1'b0) begin n_fail++; $display("FAIL rst_de got=%b exp=0", data_enable); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL rst_error got=%b exp=0", error); end
        n_checks++; if ({CNVST, CS, SCLK, RESET} !== 4'b1101) begin n_fail++; $display("FAIL rst_pins CNVST,CS,SCLK,RESET got=%b exp=1101", {CNVST, CS, SCLK, RESET}); end
        n_checks++; if ({OB2C, PD, RD} !== 3'b100) begin n_fail++; $display("FAIL rst_straps OB2C,PD,RD got=%b exp=100", {OB2C, PD, RD}); end
        // Release and request a conversion during the RESET hold.
        reset = 1'b0; start = 1'b1;
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            if (RESET === 1'b1) hi++;
        end
        n_checks++; if (hi != 4) begin n_fail++; $display("FAIL rst_hold_cycles got=%0d exp=4", hi); end
        @(posedge clk_in); #1 start = 1'b0;
        n_checks++; if (RESET !== 1'b0) begin n_fail++; $display("FAIL rst_hold_end got=%b exp=0", RESET); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL rst_hold_start_err got=%b exp=0", error); end
        repeat (3) @(negedge clk_in);
        n_checks++; if (CNVST !== 1'b1) begin n_fail++; $display("FAIL rst_hold_start_ignored CNVST got=%b exp=1", CNVST); end
    endtask

    task automatic test_single();
        bit seen; int n; int de0;
        de0 = de_total; sdo_word = 16'hA5C3;
        launch();
        wait_de(500, seen, n);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL single_timeout got=none exp=data_enable"); end
        n_checks++; if (n + 2 != EXP_LAT) begin n_fail++; $display("FAIL single_latency got=%0d exp=%0d", n + 2, EXP_LAT); end
        n_checks++; if (data !== 16'hA5C3) begin n_fail++; $display("FAIL single_data got=%h exp=a5c3", data); end
        settle();
        n_checks++; if (de_total - de0 != 1) begin n_fail++; $display("FAIL single_de_count got=%0d exp=1", de_total - de0); end
        n_checks++; if (last_de_w != 1) begin n_fail++; $display("FAIL single_de_width got=%0d exp=1", last_de_w); end
        n_checks++; if (last_cnv_low != T_CNV) begin n_fail++; $display("FAIL single_cnvst_low got=%0d exp=%0d", last_cnv_low, T_CNV); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL single_error got=%b exp=0", error); end
        repeat (20) @(negedge clk_in);
        n_checks++; if (data !== 16'hA5C3) begin n_fail++; $display("FAIL single_data_hold got=%h exp=a5c3", data); end
    endtask

    task automatic test_back_to_back();
        bit seen; int n; int de0;
        logic [15:0] words [2];
        words[0] = 16'h0000; words[1] = 16'hFFFF;
        de0 = de_total;
        for (int k = 0; k < 2; k++) begin
            sdo_word = words[k];
            launch();
            wait_de(500, seen, n);
            n_checks++; if (!seen || data !== words[k]) begin n_fail++; $display("FAIL b2b_data%0d got=%h seen=%b exp=%h", k, data, seen, words[k]); end
            settle();
            n_checks++; if (last_sclk != 16) begin n_fail++; $display("FAIL b2b_sclk%0d got=%0d exp=16", k, last_sclk); end
            n_checks++; if (last_cs_low != 32 * T_SH) begin n_fail++; $display("FAIL b2b_cs_low%0d got=%0d exp=%0d", k, last_cs_low, 32 * T_SH); end
        end
        n_checks++; if (de_total - de0 != 2) begin n_fail++; $display("FAIL b2b_de_count got=%0d exp=2", de_total - de0); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL b2b_error got=%b exp=0", error); end
    endtask

    task automatic test_double_start();
        bit seen; int n; int de0;
        de0 = de_total; sdo_word = 16'h6E19;
        launch();
        repeat (2) @(negedge clk_in);
        start = 1'b1;
        @(negedge clk_in); start = 1'b0;
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL dbl_error got=%b exp=1", error); end
        wait_de(500, seen, n);
        n_checks++; if (!seen || data !== 16'h6E19) begin n_fail++; $display("FAIL dbl_data got=%h seen=%b exp=6e19", data, seen); end
        repeat (150) @(negedge clk_in);
        @(posedge clk_in); #1;
        n_checks++; if (de_total - de0 != 1) begin n_fail++; $display("FAIL dbl_de_count got=%0d exp=1", de_total - de0); end
    endtask

    task automatic test_start_at_done();
        int de0;
        de0 = de_total; sdo_word = 16'h0F0F;
        launch();
        // Now at the negedge after the accepting edge; DONE is entered
        // EXP_LAT-2 edges later, so raise start one negedge before that.
        repeat (EXP_LAT - 3) @(negedge clk_in);
        start = 1'b1;
        @(negedge clk_in); start = 1'b0;
        n_checks++; if (data_enable !== 1'b1 || data !== 16'h0F0F) begin n_fail++; $display("FAIL done_start_strobe got=%b/%h exp=1/0f0f", data_enable, data); end
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL done_start_error got=%b exp=1", error); end
        repeat (150) @(negedge clk_in);
        @(posedge clk_in); #1;
        n_checks++; if (de_total - de0 != 1) begin n_fail++; $display("FAIL done_start_ignored de got=%0d exp=1", de_total - de0); end
    endtask

    task automatic test_rderror();
        bit seen; int n;
        sdo_word = 16'h1234; rderr_bit = 7;
        launch();
        wait_de(500, seen, n);
        rderr_bit = -1;
        n_checks++; if (!seen || data !== 16'h1234) begin n_fail++; $display("FAIL rderr_data got=%h seen=%b exp=1234", data, seen); end
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL rderr_error got=%b exp=1", error); end
        settle();
        sdo_word = 16'h5678;
        launch();
        wait_de(500, seen, n);
        n_checks++; if (!seen || data !== 16'h5678) begin n_fail++; $display("FAIL rderr_clean_data got=%h seen=%b exp=5678", data, seen); end
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL rderr_sticky got=%b exp=1", error); end
        settle();
    endtask

    task automatic test_reset_mid_read();
        bit found; int de0; int hi;
        sdo_word = 16'hBEEF; found = 1'b0;
        launch();
        for (int i = 0; i < 500 && !found; i++) begin
            @(posedge clk_in); #1;
            if (!CS && m_bit == 10) found = 1'b1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL midrd_reach_bit10 got=none exp=bit10"); end
        de0 = de_total;
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({CNVST, CS, SCLK, RESET} !== 4'b1101) begin n_fail++; $display("FAIL midrd_pins got=%b exp=1101", {CNVST, CS, SCLK, RESET}); end
        n_checks++; if (data !== 16'h0000 || data_enable !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL midrd_regs got=%h/%b/%b exp=0000/0/0", data, data_enable, error); end
        @(posedge clk_in); #1 reset = 1'b0;
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            if (RESET === 1'b1) hi++;
        end
        @(posedge clk_in); #1;
        n_checks++; if (hi != 4 || RESET !== 1'b0) begin n_fail++; $display("FAIL midrd_hold got=%0d/%b exp=4/0", hi, RESET); end
        repeat (200) @(negedge clk_in);
        @(posedge clk_in); #1;
        n_checks++; if (de_total != de0 || CS !== 1'b1) begin n_fail++; $display("FAIL midrd_no_de got=%0d/%b exp=%0d/1", de_total, CS, de0); end
    endtask

    task automatic test_busy_stuck();
        bit seen; int n; int de0;
        de0 = de_total;
        busy_stuck = 1'b1;
        launch();
`ifdef ADC_BUSY_TIMEOUT_EN
        n = 0;
        while (error !== 1'b1 && n < 3000) begin @(negedge clk_in); n++; end
        n_checks++; if (n + 2 != 1 + T_CNV + T_TO + 1) begin n_fail++; $display("FAIL to_latency got=%0d exp=%0d", n + 2, 1 + T_CNV + T_TO + 1); end
        n_checks++; if (CS !== 1'b1 || CNVST !== 1'b1) begin n_fail++; $display("FAIL to_idle CS,CNVST got=%b%b exp=11", CS, CNVST); end
        repeat (5) @(negedge clk_in);
        busy_stuck = 1'b0;
        sdo_word = 16'h3C5A;
        launch();
`else
        repeat (1100) @(negedge clk_in);
        @(posedge clk_in); #1;
        n_checks++; if (error !== 1'b0 || CS !== 1'b1) begin n_fail++; $display("FAIL wait_err_cs got=%b/%b exp=0/1", error, CS); end
        n_checks++; if (de_total != de0) begin n_fail++; $display("FAIL wait_no_de got=%0d exp=%0d", de_total, de0); end
        sdo_word = 16'h3C5A;
        busy_stuck = 1'b0;
`endif
        wait_de(500, seen, n);
        n_checks++; if (!seen || data !== 16'h3C5A) begin n_fail++; $display("FAIL busy_recover_data got=%h seen=%b exp=3c5a", data, seen); end
        settle();
        n_checks++; if (de_total - de0 != 1) begin n_fail++; $display("FAIL busy_de_count got=%0d exp=1", de_total - de0); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_double_start();
        do_reset();
        test_start_at_done();
        do_reset();
        test_rderror();
        test_reset_mid_read();
        test_busy_stuck();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
